// File: rtl/fb_text_writer.sv
// fb_text_writer: terminal-style glyph writer into a 16-bit frame buffer holding two glyphs per word.
// Printable codes use read-modify-write; LF/CR/BS move the cursor; FF blanks the whole screen.
module fb_text_writer #(
    parameter logic [15:0] FRAME_BUFFER_START = 16'hF000,
    parameter int          ROW_STRIDE         = 80,
    parameter logic [7:0]  BLANK_GLYPH        = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row
);
    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, CLEAR} state_t;
    state_t state, state_n;
    logic [7:0]  ch;
    logic [5:0]  clr_word, clr_row;
    logic [15:0] cell_addr;
    logic [5:0]  row_inc;
    logic        is_lf, is_cr, is_bs, is_ff, clr_last;
    assign is_lf     = char_data == 8'h0A;
    assign is_cr     = char_data == 8'h0D;
    assign is_bs     = char_data == 8'h08;
    assign is_ff     = char_data == 8'h0C;
    assign clr_last  = clr_row == 6'd59 && clr_word == 6'd39;
    assign row_inc   = cursor_row == 6'd59 ? 6'd0 : cursor_row + 6'd1;
    assign cell_addr = FRAME_BUFFER_START + 16'(ROW_STRIDE) * {10'd0, cursor_row} + {10'd0, cursor_col[6:1]};
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_n;
    always_comb begin
        state_n    = state;
        char_ready = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                char_ready = 1'b1;
                if (char_valid) state_n = is_ff ? CLEAR : (is_lf || is_cr || is_bs) ? IDLE : READ;
            end
            READ:  state_n = MERGE;
            MERGE: state_n = WRITE;
            WRITE: begin
                mem_we  = 1'b1;
                state_n = IDLE;
            end
            CLEAR: begin
                mem_we  = 1'b1;
                state_n = clr_last ? IDLE : CLEAR;
            end
            default: state_n = IDLE;
        endcase
    end
    // Control codes update the cursor at the accepting edge; nothing touches memory for them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr   <= FRAME_BUFFER_START;
            mem_wdata  <= 16'h0;
            cursor_col <= 7'd0;
            cursor_row <= 6'd0;
            ch         <= 8'h0;
            clr_word   <= 6'd0;
            clr_row    <= 6'd0;
        end else begin
            case (state)
                IDLE: if (char_valid) begin
                    if (is_lf) begin
                        cursor_col <= 7'd0;
                        cursor_row <= row_inc;
                    end else if (is_cr) begin
                        cursor_col <= 7'd0;
                    end else if (is_bs) begin
                        if (cursor_col != 7'd0) begin
                            cursor_col <= cursor_col - 7'd1;
                        end else if (cursor_row != 6'd0) begin
                            cursor_col <= 7'd79;
                            cursor_row <= cursor_row - 6'd1;
                        end
                    end else if (is_ff) begin
                        mem_addr  <= FRAME_BUFFER_START;
                        mem_wdata <= {BLANK_GLYPH, BLANK_GLYPH};
                        clr_word  <= 6'd0;
                        clr_row   <= 6'd0;
                    end else begin
                        ch       <= char_data;
                        mem_addr <= cell_addr;
                    end
                end
                MERGE: mem_wdata <= cursor_col[0] ? {mem_rdata[15:8], ch} : {ch, mem_rdata[7:0]};
                WRITE: begin
                    cursor_col <= cursor_col == 7'd79 ? 7'd0 : cursor_col + 7'd1;
                    if (cursor_col == 7'd79) cursor_row <= row_inc;
                end
                CLEAR: begin
                    if (clr_last) begin
                        cursor_col <= 7'd0;
                        cursor_row <= 6'd0;
                    end else begin
                        // Skip from the last word of a row to the start of the next row.
                        clr_word <= clr_word == 6'd39 ? 6'd0 : clr_word + 6'd1;
                        if (clr_word == 6'd39) clr_row <= clr_row + 6'd1;
                        mem_addr <= mem_addr + (clr_word == 6'd39 ? 16'(ROW_STRIDE - 39) : 16'd1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_text_writer.sv
// tb_fb_text_writer: table-driven cursor/write vectors plus hand sequences, with a write scoreboard.
module tb_fb_text_writer;
    logic        clk, reset, char_valid, char_ready, mem_we;
    logic [7:0]  char_data;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        poke_en;
    logic [15:0] poke_addr, poke_data;
    int vectors = 0, miscompares = 0, writes_seen = 0;

    typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
    typedef struct { logic [7:0] ch; logic [6:0] col; logic [5:0] row; logic wr; logic [15:0] addr; logic [15:0] data; } vec_t;
    wr_t  exp_q[$];
    vec_t tbl[14];
    logic [15:0] mem [int];

    fb_text_writer dut (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cursor_col(cursor_col), .cursor_row(cursor_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-buffer model: one-cycle read latency, writes on mem_we, bench pokes for preload.
    always @(posedge clk) begin
        mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 16'h0;
        if (poke_en) mem[int'(poke_addr)] = poke_data;
        else if (mem_we && reset) mem[int'(mem_addr)] = mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (reset && mem_we) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected write: addr %0h data %0h expected none", mem_addr, mem_wdata);
        end else begin
            wr_t w;
            w = exp_q.pop_front();
            chk("write addr", mem_addr, w.addr);
            chk("write data", mem_wdata, w.data);
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!char_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle timeout", char_ready, 1);
    endtask

    task automatic send(input logic [7:0] c);
        wait_idle();
        char_valid = 1'b1;
        char_data  = c;
        @(posedge clk);
        #1 char_valid = 1'b0;
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic chk_cursor(input string nm, input logic [6:0] c, input logic [5:0] r);
        chk({nm, " col"}, cursor_col, c);
        chk({nm, " row"}, cursor_row, r);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0, low, n;
        tbl[0]  = '{8'h42,  7'd2, 6'd0, 1'b1, 16'hF000, 16'h4142};
        tbl[1]  = '{8'h0D,  7'd0, 6'd0, 1'b0, 16'h0,    16'h0};
        tbl[2]  = '{8'h0A,  7'd0, 6'd1, 1'b0, 16'h0,    16'h0};
        tbl[3]  = '{8'h0A,  7'd0, 6'd2, 1'b0, 16'h0,    16'h0};
        tbl[4]  = '{8'h0A,  7'd0, 6'd3, 1'b0, 16'h0,    16'h0};
        tbl[5]  = '{8'h08, 7'd79, 6'd2, 1'b0, 16'h0,    16'h0};
        tbl[6]  = '{8'h43,  7'd0, 6'd3, 1'b1, 16'hF0C7, 16'hAB43};
        tbl[7]  = '{8'h08, 7'd79, 6'd2, 1'b0, 16'h0,    16'h0};
        tbl[8]  = '{8'h08, 7'd78, 6'd2, 1'b0, 16'h0,    16'h0};
        tbl[9]  = '{8'h5A, 7'd79, 6'd2, 1'b1, 16'hF0C7, 16'h5A43};
        tbl[10] = '{8'h0D,  7'd0, 6'd2, 1'b0, 16'h0,    16'h0};
        tbl[11] = '{8'h08, 7'd79, 6'd1, 1'b0, 16'h0,    16'h0};
        tbl[12] = '{8'h61,  7'd0, 6'd2, 1'b1, 16'hF077, 16'h0061};
        tbl[13] = '{8'h0C,  7'd0, 6'd0, 1'b0, 16'h0,    16'h0};
        reset = 1'b0; char_valid = 1'b0; char_data = 8'h0;
        poke_en = 1'b0; poke_addr = 16'h0; poke_data = 16'h0;
        poke(16'hF000, 16'h1234);
        poke(16'hF0C7, 16'hABCD);
        chk("reset ready", char_ready, 1);
        chk("reset we", mem_we, 0);
        chk("reset addr", mem_addr, 16'hF000);
        chk("reset wdata", mem_wdata, 16'h0);
        chk_cursor("reset", 7'd0, 6'd0);
        @(negedge clk) reset = 1'b1;
        // First printable: cycle-by-cycle read-modify-write timing.
        exp_q.push_back('{16'hF000, 16'h4134});
        send(8'h41);
        @(negedge clk);
        chk("T+1 we", mem_we, 0);
        chk("T+1 addr", mem_addr, 16'hF000);
        chk("T+1 ready", char_ready, 0);
        @(negedge clk);
        chk("T+2 we", mem_we, 0);
        @(negedge clk);
        chk("T+3 we", mem_we, 1);
        @(negedge clk);
        chk("T+4 ready", char_ready, 1);
        chk_cursor("after 0x41", 7'd1, 6'd0);
        // Table: last row (FF) is exercised separately below.
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].wr) exp_q.push_back('{tbl[i].addr, tbl[i].data});
            w0 = writes_seen;
            send(tbl[i].ch);
            wait_idle();
            chk_cursor($sformatf("vec %0d", i), tbl[i].col, tbl[i].row);
            chk($sformatf("vec %0d writes", i), writes_seen - w0, {31'd0, tbl[i].wr});
        end
        // Clear screen while a char is offered the whole time.
        for (int r = 0; r < 60; r++)
            for (int w = 0; w < 40; w++)
                exp_q.push_back('{16'(32'hF000 + r * 80 + w), 16'h2020});
        w0 = writes_seen;
        send(tbl[13].ch);
        char_valid = 1'b1; char_data = 8'h51;
        low = 0; n = 0;
        @(negedge clk);
        while (!char_ready && n < 3000) begin
            low++; n++;
            @(negedge clk);
        end
        char_valid = 1'b0;
        chk("clear ready-low cycles", low, 2400);
        chk("clear writes", writes_seen - w0, 2400);
        chk_cursor("after clear", tbl[13].col, tbl[13].row);
        repeat (3) @(negedge clk);
        chk("offered char ignored", writes_seen - w0, 2400);
        chk_cursor("offered char ignored", 7'd0, 6'd0);
        // LF wrap at row 59.
        for (int i = 0; i < 59; i++) send(8'h0A);
        wait_idle();
        chk_cursor("59 LFs", 7'd0, 6'd59);
        w0 = writes_seen;
        send(8'h0A);
        wait_idle();
        chk_cursor("LF at row 59", 7'd0, 6'd0);
        chk("LF writes", writes_seen - w0, 0);
        // Fill row 59 with 'X' to reach (59,79), then wrap to (0,0).
        for (int i = 0; i < 59; i++) send(8'h0A);
        for (int c = 0; c < 80; c++) begin
            exp_q.push_back('{16'(32'hF000 + 59 * 80 + c / 2), (c % 2) ? 16'h5858 : 16'h5820});
            send(8'h58);
            if (c == 78) begin
                wait_idle();
                chk_cursor("row 59 col 79", 7'd79, 6'd59);
            end
        end
        wait_idle();
        chk_cursor("wrap from (59,79)", 7'd0, 6'd0);
        w0 = writes_seen;
        send(8'h08);
        wait_idle();
        chk_cursor("BS at (0,0)", 7'd0, 6'd0);
        for (int i = 0; i < 5; i++) send(8'h0A);
        send(8'h08);
        wait_idle();
        chk_cursor("BS at (5,0)", 7'd79, 6'd4);
        chk("ctrl writes", writes_seen - w0, 0);
        // Asynchronous reset in the middle of MERGE: the write must never happen.
        w0 = writes_seen;
        send(8'h44);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async rst ready", char_ready, 1);
        chk("async rst we", mem_we, 0);
        chk("async rst addr", mem_addr, 16'hF000);
        chk("async rst wdata", mem_wdata, 16'h0);
        chk_cursor("async rst", 7'd0, 6'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("aborted char writes", writes_seen - w0, 0);
        chk("ready after abort", char_ready, 1);
        chk_cursor("after abort", 7'd0, 6'd0);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fb_text_writer.md
FB_TEXT_WRITER -- requirements
Module: fb_text_writer

Interface
REQ-001 SHALL have parameter FRAME_BUFFER_START, 16'hF000, word address of glyph cell (row 0, col 0).
REQ-002 SHALL have parameter ROW_STRIDE, 80, words between consecutive glyph rows.
REQ-003 SHALL have parameter BLANK_GLYPH, 8'h20, glyph code written by clear-screen.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port char_valid  input  1  producer offers char_data.
REQ-007 SHALL have port char_data  input  8  character/control code.
REQ-008 SHALL have port char_ready  output  1  block accepts char this cycle.
REQ-009 SHALL have port mem_addr  output  16  frame-buffer word address.
REQ-010 SHALL have port mem_we  output  1  write strobe, one cycle per write.
REQ-011 SHALL have port mem_wdata  output  16  write data.
REQ-012 SHALL have port mem_rdata  input  16  read data; valid the cycle after mem_addr is presented with mem_we=0.
REQ-013 SHALL have port cursor_col  output  7  current glyph column, 0..79.
REQ-014 SHALL have port cursor_row  output  6  current glyph row, 0..59.

Function
REQ-015 SHALL transfer a char only on a rising edge with char_valid=1 and char_ready=1; char_valid while char_ready=0 is ignored.
REQ-016 SHALL assert char_ready only in state IDLE.
REQ-017 SHALL map cell (row, col) to word FRAME_BUFFER_START + ROW_STRIDE*row + col[6:1], all arithmetic modulo 2^16 (wrap past 16'hFFFF is intended, matching the display read mapping).
REQ-018 SHALL place even col in mem bits [15:8], odd col in [7:0]; the other byte is preserved.
REQ-019 SHALL handle printable codes (anything not listed in REQ-023..026) by read-modify-write: IDLE -> READ -> MERGE -> WRITE -> IDLE.
REQ-020 SHALL, accepting at edge T: READ during cycle T+1 (mem_addr=cell word, mem_we=0); MERGE during T+2 (capture mem_rdata, substitute byte); WRITE during T+3 (mem_we=1, mem_wdata=merged); IDLE and char_ready=1 from T+4.
REQ-021 SHALL hold mem_we=0 in every state except WRITE and CLEAR.
REQ-022 SHALL advance cursor on leaving WRITE: col+1; col 79 -> col 0, row+1; row 59 -> row 0.
REQ-023 SHALL handle 0x0A (LF): col=0, row+1 with 59->0 wrap, no memory access, return to IDLE next cycle.
REQ-024 SHALL handle 0x0D (CR): col=0, row unchanged, no memory access.
REQ-025 SHALL handle 0x08 (BS): col>0 -> col-1; col=0,row>0 -> col=79,row-1; col=0,row=0 -> unchanged; no memory access.
REQ-026 SHALL handle 0x0C (FF): enter CLEAR, write {BLANK_GLYPH,BLANK_GLYPH} to words row 0..59 x word 0..39, row-major, one write per cycle (2400 cycles), then cursor (0,0) and IDLE.
REQ-027 SHALL keep char_ready=0 for the full CLEAR sequence; char_valid during CLEAR is not consumed.
REQ-028 SHALL change cursor outputs only at the points defined in REQ-022..026.
REQ-029 SHALL drive mem_addr and mem_wdata from registers; values outside READ/WRITE/CLEAR are don't-care except at reset.

Reset
REQ-030 SHALL, while reset=0, force state IDLE, char_ready=1, mem_we=0, mem_addr=FRAME_BUFFER_START, mem_wdata=0, cursor (0,0), independent of clk.
REQ-031 SHALL abort any RMW or CLEAR on reset with no further write; frame-buffer contents are not cleared by reset.

Verification
REQ-032 SHALL verify: reset, word F000=16'h1234, send 0x41 -> T+1 read F000, T+3 mem_we=1 addr F000 wdata 16'h4134, cursor (0,1), char_ready=1 at T+4.
REQ-033 SHALL verify: cursor (0,1), word F000=16'h4134, send 0x42 -> wdata 16'h4142 at F000, cursor (0,2).
REQ-034 SHALL verify: cursor (2,79), send 0x43 -> write addr 16'hF0C7 low byte, cursor (3,0); cursor (59,79) printable -> cursor (0,0).
REQ-035 SHALL verify: send 0x0C -> exactly 2400 writes of 16'h2020, first addr 16'hF000, last 16'h0297, char_ready=0 throughout, then cursor (0,0).
REQ-036 SHALL verify: 0x0A at row 59 -> (0,0); 0x08 at (0,0) -> (0,0); 0x08 at (5,0) -> (4,79); none assert mem_we.
REQ-037 SHALL verify: reset=0 asserted asynchronously during MERGE -> mem_we never asserted for that char, cursor (0,0), char_ready=1 immediately.
